// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: tracks outstanding writes per architectural register
// and grants the register-read stage only when no source or destination hazard exists.
module reg_scoreboard #(
    parameter int unsigned MAX_PENDING = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issueValidIn,
    input  logic [3:0]  sourceReg1In,
    input  logic [3:0]  sourceReg2In,
    input  logic        sourceReg1ValidIn,
    input  logic        sourceReg2ValidIn,
    input  logic [3:0]  destRegIn,
    input  logic        destRegValidIn,
    input  logic [3:0]  destRegisterSpecialIn,
    input  logic        destRegisterSpecialValidIn,
    input  logic        stallIn,
    input  logic        wbStallIn,
    input  logic        wbValidIn,
    input  logic [3:0]  wbRegIn,
    input  logic        wbSpecialValidIn,
    input  logic [3:0]  wbSpecialRegIn,
    input  logic        flushIn,
    output logic        canReadOut,
    output logic        hazardStallOut,
    output logic [15:0] busyMaskOut,
    output logic [15:0] stallCountOut,
    output logic        underflowErrOut
);

    localparam int unsigned NumRegs = 16;
    localparam logic [1:0]  MaxCount = 2'(MAX_PENDING);

    logic [1:0]  count_q [NumRegs];
    logic [1:0]  count_d [NumRegs];
    logic [15:0] stallCount_q;
    logic [15:0] stallCount_d;
    logic        underflow_q;
    logic        underflow_d;

    logic        srcHaz;
    logic        dstHaz;
    logic        issueOk;
    logic        grant;
    logic        underflowHit;
    logic [15:0] reserveVec;
    logic [15:0] releaseVec;

    // Hazard detection looks only at registered counts; a writeback this cycle
    // cannot unblock a reader until the following cycle.
    always_comb begin
        srcHaz  = (sourceReg1ValidIn && (count_q[sourceReg1In] != 2'd0)) ||
                  (sourceReg2ValidIn && (count_q[sourceReg2In] != 2'd0));
        dstHaz  = (destRegValidIn && (count_q[destRegIn] == MaxCount)) ||
                  (destRegisterSpecialValidIn && (count_q[destRegisterSpecialIn] == MaxCount));
        issueOk = issueValidIn && !stallIn && !wbStallIn && !flushIn;
        grant   = issueOk && !srcHaz && !dstHaz;
    end

    assign canReadOut     = grant;
    assign hazardStallOut = issueOk && (srcHaz || dstHaz);

    // Matching on register index per counter makes a repeated register
    // (special == dest, or wbSpecial == wb) count only once.
    always_comb begin
        reserveVec = '0;
        releaseVec = '0;
        for (int r = 0; r < NumRegs; r++) begin
            reserveVec[r] = grant &&
                            ((destRegValidIn && (destRegIn == 4'(r))) ||
                             (destRegisterSpecialValidIn && (destRegisterSpecialIn == 4'(r))));
            releaseVec[r] = (wbValidIn && (wbRegIn == 4'(r))) ||
                            (wbSpecialValidIn && (wbSpecialRegIn == 4'(r)));
        end
    end

    always_comb begin
        underflowHit = 1'b0;
        for (int r = 0; r < NumRegs; r++) begin
            count_d[r] = count_q[r];
            if (flushIn) begin
                count_d[r] = 2'd0;
            end else if (reserveVec[r] && !releaseVec[r]) begin
                count_d[r] = count_q[r] + 2'd1;
            end else if (releaseVec[r] && !reserveVec[r]) begin
                if (count_q[r] == 2'd0) begin
                    underflowHit = 1'b1;
                end else begin
                    count_d[r] = count_q[r] - 2'd1;
                end
            end
        end
    end

    always_comb begin
        stallCount_d = stallCount_q;
        if (hazardStallOut && (stallCount_q != 16'hFFFF)) begin
            stallCount_d = stallCount_q + 16'd1;
        end
        underflow_d = underflow_q | underflowHit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NumRegs; r++) begin
                count_q[r] <= 2'd0;
            end
            stallCount_q <= 16'd0;
            underflow_q  <= 1'b0;
        end else begin
            for (int r = 0; r < NumRegs; r++) begin
                count_q[r] <= count_d[r];
            end
            stallCount_q <= stallCount_d;
            underflow_q  <= underflow_d;
        end
    end

    always_comb begin
        busyMaskOut = '0;
        for (int r = 0; r < NumRegs; r++) begin
            busyMaskOut[r] = (count_q[r] != 2'd0);
        end
    end

    assign stallCountOut   = stallCount_q;
    assign underflowErrOut = underflow_q;

endmodule
